// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   ldState_t  : loader FSM state encoding
//   ADDR_W_DEF : default instruction memory address width (16-bit words)
//   WORD_W_DEF : default instruction word width
package imem_loader_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int WORD_W_DEF = 16;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_LOAD   = 3'd1,
    LD_VERIFY = 3'd2,
    LD_DONE   = 3'd3,
    LD_ERROR  = 3'd4
  } ldState_t;

endpackage

// File: rtl/imem_loader_sum_acc.sv
// ld_sum_acc: WORD_W modular accumulator.
//   clk    : clock
//   rst    : synchronous active-low reset (sum -> 0)
//   clr    : synchronous clear, wins over en
//   en     : add addend this cycle
//   addend : value to add
//   sum    : running sum mod 2^WORD_W
module ld_sum_acc #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [WORD_W-1:0] addend,
  output logic [WORD_W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (!rst)     sum <= '0;
    else if (clr) sum <= '0;
    else if (en)  sum <= sum + addend;
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes a host word stream into instruction memory, reads it
// back, and releases the processor only when the read-back sum matches.
//   clk, rst          : clock, synchronous active-low reset
//   start             : begin a load (accepted in IDLE, DONE, ERROR)
//   base_addr         : first word address, sampled on accepted start
//   word_count        : number of words, sampled on accepted start
//   in_valid/in_ready : host word handshake, in_data is the word
//   mem_we/mem_addr/mem_wdata : memory write port (write lands on clk edge)
//   mem_rdata         : combinational read data for mem_addr
//   cpu_hold          : 1 holds Fetch in stall/reset
//   done, error       : load verified / range or checksum failure
//   checksum          : running sum of accepted words
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [WORD_W-1:0] checksum
);

  // Range check is done two bits wider than the address so that neither
  // base+count nor the 2^ADDR_W limit can wrap.
  localparam logic [ADDR_W+1:0] MEM_WORDS = (ADDR_W+2)'(1) << ADDR_W;

  ldState_t          state, stateNxt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   count, idx;
  logic [WORD_W-1:0] wsum, rsum, rsumFinal;
  logic [ADDR_W+1:0] endAddr;
  logic [ADDR_W-1:0] curAddr;
  logic              startOk, rangeBad, lastIdx, hs, inVerify;

  assign startOk   = start && (state == LD_IDLE || state == LD_DONE || state == LD_ERROR);
  assign endAddr   = {2'b00, base_addr} + {1'b0, word_count};
  assign rangeBad  = endAddr > MEM_WORDS;
  assign lastIdx   = (idx == count - 1'b1);
  assign hs        = (state == LD_LOAD) && in_valid;
  assign inVerify  = (state == LD_VERIFY);
  // The last read word is not yet in rsum when the decision is made.
  assign rsumFinal = rsum + mem_rdata;
  // idx never exceeds count-1 < 2^ADDR_W, so the low bits suffice.
  assign curAddr   = base + idx[ADDR_W-1:0];

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= LD_IDLE;
    else      state <= stateNxt;
  end

  // next state
  always_comb begin
    stateNxt = state;
    case (state)
      LD_IDLE, LD_DONE, LD_ERROR:
        if (start) begin
          if (word_count == '0) stateNxt = LD_DONE;
          else if (rangeBad)    stateNxt = LD_ERROR;
          else                  stateNxt = LD_LOAD;
        end
      LD_LOAD:   if (in_valid && lastIdx) stateNxt = LD_VERIFY;
      LD_VERIFY: if (lastIdx) stateNxt = (rsumFinal == wsum) ? LD_DONE : LD_ERROR;
      default:   stateNxt = LD_IDLE;
    endcase
  end

  // outputs, all decoded from registered state plus pass-through data
  always_comb begin
    in_ready  = (state == LD_LOAD);
    mem_we    = hs;
    mem_addr  = {{(32-ADDR_W){1'b0}}, curAddr};
    mem_wdata = in_data;
    cpu_hold  = (state != LD_DONE);
    done      = (state == LD_DONE);
    error     = (state == LD_ERROR);
    checksum  = wsum;
  end

  // base/count/idx datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      base  <= '0;
      count <= '0;
      idx   <= '0;
    end else if (startOk) begin
      base  <= base_addr;
      count <= word_count;
      idx   <= '0;
    end else if (hs || inVerify) begin
      idx   <= lastIdx ? '0 : idx + 1'b1;
    end
  end

  ld_sum_acc #(.WORD_W(WORD_W)) uWsum (
    .clk    (clk),
    .rst    (rst),
    .clr    (startOk),
    .en     (hs),
    .addend (in_data),
    .sum    (wsum)
  );

  ld_sum_acc #(.WORD_W(WORD_W)) uRsum (
    .clk    (clk),
    .rst    (rst),
    .clr    (startOk),
    .en     (inVerify),
    .addend (mem_rdata),
    .sum    (rsum)
  );

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] base_addr;
  logic [20:0] word_count;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] checksum;

  int vectors = 0;
  int miscompares = 0;

  // memory model: low 12 address bits, optional read corruption
  logic [15:0] mem [0:4095];
  int          weCount = 0;
  logic        corrupt = 1'b0;
  logic [31:0] corruptAddr = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[11:0]] <= mem_wdata;
      weCount <= weCount + 1;
    end
  end

  assign mem_rdata = mem[mem_addr[11:0]] ^ ((corrupt && mem_addr == corruptAddr) ? 16'h0001 : 16'h0000);

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .checksum(checksum)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [19:0] b, input logic [20:0] c);
    base_addr = b; word_count = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; base_addr = '0; word_count = '0;
    tick(); tick();
    vectors++; if (cpu_hold !== 1'b1) begin $display("FAIL reset_hold got %b want 1", cpu_hold); miscompares++; end
    vectors++; if (done !== 1'b0 || error !== 1'b0) begin $display("FAIL reset_flags got done=%b err=%b want 0/0", done, error); miscompares++; end
    vectors++; if (in_ready !== 1'b0 || mem_we !== 1'b0) begin $display("FAIL reset_port got rdy=%b we=%b want 0/0", in_ready, mem_we); miscompares++; end
    vectors++; if (checksum !== 16'h0) begin $display("FAIL reset_sum got %h want 0000", checksum); miscompares++; end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_load();
    logic [15:0] w [3];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h0003;
    do_start(20'h10, 21'd3);
    vectors++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin $display("FAIL basic_load_state got rdy=%b hold=%b want 1/1", in_ready, cpu_hold); miscompares++; end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = w[i]; #1;
      vectors++; if (mem_we !== 1'b1 || mem_addr !== 32'h10 + i || mem_wdata !== w[i])
        begin $display("FAIL basic_wr%0d got we=%b a=%h d=%h want 1 %h %h", i, mem_we, mem_addr, mem_wdata, 32'h10 + i, w[i]); miscompares++; end
      tick();
    end
    in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b0 || mem_we !== 1'b0) begin $display("FAIL basic_verify_port got rdy=%b we=%b want 0/0", in_ready, mem_we); miscompares++; end
    tick(); tick();
    vectors++; if (done !== 1'b0) begin $display("FAIL basic_verify_lat got done=%b want 0 after 2 cycles", done); miscompares++; end
    tick();
    vectors++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin $display("FAIL basic_done got done=%b hold=%b err=%b want 1/0/0", done, cpu_hold, error); miscompares++; end
    vectors++; if (checksum !== 16'h3336) begin $display("FAIL basic_sum got %h want 3336", checksum); miscompares++; end
    vectors++; if (mem[12'h10] !== 16'h1111 || mem[12'h11] !== 16'h2222 || mem[12'h12] !== 16'h0003)
      begin $display("FAIL basic_mem got %h %h %h want 1111 2222 0003", mem[12'h10], mem[12'h11], mem[12'h12]); miscompares++; end
  endtask

  task automatic test_backpressure();
    logic [15:0] w [3];
    int we0;
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h0003;
    do_start(20'h30, 21'd3);
    vectors++; if (done !== 1'b0 || cpu_hold !== 1'b1 || checksum !== 16'h0) begin $display("FAIL bp_restart got done=%b hold=%b sum=%h want 0/1/0000", done, cpu_hold, checksum); miscompares++; end
    we0 = weCount;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0;
      for (int g = 0; g < 2; g++) begin
        #1;
        vectors++; if (mem_we !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL bp_gap got we=%b rdy=%b want 0/1", mem_we, in_ready); miscompares++; end
        tick();
      end
      in_valid = 1'b1; in_data = w[i]; #1;
      vectors++; if (mem_addr !== 32'h30 + i) begin $display("FAIL bp_addr%0d got %h want %h", i, mem_addr, 32'h30 + i); miscompares++; end
      tick();
    end
    in_valid = 1'b0;
    vectors++; if (weCount - we0 !== 3) begin $display("FAIL bp_we_count got %0d want 3", weCount - we0); miscompares++; end
    tick(); tick(); tick();
    vectors++; if (done !== 1'b1 || checksum !== 16'h3336) begin $display("FAIL bp_done got done=%b sum=%h want 1 3336", done, checksum); miscompares++; end
    vectors++; if (mem[12'h30] !== 16'h1111 || mem[12'h31] !== 16'h2222 || mem[12'h32] !== 16'h0003)
      begin $display("FAIL bp_mem got %h %h %h want 1111 2222 0003", mem[12'h30], mem[12'h31], mem[12'h32]); miscompares++; end
  endtask

  task automatic test_range_error();
    int we0;
    we0 = weCount;
    do_start(20'hFFFFE, 21'd3);
    vectors++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin $display("FAIL range_err got err=%b hold=%b done=%b want 1/1/0", error, cpu_hold, done); miscompares++; end
    in_valid = 1'b1; in_data = 16'hDEAD;
    tick(); tick();
    vectors++; if (in_ready !== 1'b0 || weCount !== we0) begin $display("FAIL range_nowrite got rdy=%b writes=%0d want 0/0", in_ready, weCount - we0); miscompares++; end
    in_valid = 1'b0;
  endtask

  task automatic test_range_boundary();
    // base+count == 2^ADDR_W exactly is legal; last word at 0xFFFFF
    do_start(20'hFFFFE, 21'd2);
    vectors++; if (error !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL edge_accept got err=%b rdy=%b want 0/1", error, in_ready); miscompares++; end
    in_valid = 1'b1; in_data = 16'hA000; tick();
    in_data = 16'h0B00; #1;
    vectors++; if (mem_addr !== 32'h000FFFFF) begin $display("FAIL edge_addr got %h want 000fffff", mem_addr); miscompares++; end
    tick();
    in_valid = 1'b0;
    tick(); tick();
    vectors++; if (done !== 1'b1 || checksum !== 16'hAB00) begin $display("FAIL edge_done got done=%b sum=%h want 1 ab00", done, checksum); miscompares++; end
  endtask

  task automatic test_verify_mismatch();
    corrupt = 1'b1; corruptAddr = 32'h21;
    do_start(20'h20, 21'd3);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'(i + 1); tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    vectors++; if (done !== 1'b0 || error !== 1'b0) begin $display("FAIL mis_early got done=%b err=%b want 0/0", done, error); miscompares++; end
    tick();
    vectors++; if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin $display("FAIL mis_err got err=%b done=%b hold=%b want 1/0/1", error, done, cpu_hold); miscompares++; end
    vectors++; if (checksum !== 16'h0006) begin $display("FAIL mis_sum got %h want 0006", checksum); miscompares++; end
    corrupt = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    do_start(20'h40, 21'd4);
    vectors++; if (error !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL mid_start got err=%b rdy=%b want 0/1", error, in_ready); miscompares++; end
    in_valid = 1'b1; in_data = 16'h5555; tick();
    in_valid = 1'b0;
    vectors++; if (checksum !== 16'h5555) begin $display("FAIL mid_partial got %h want 5555", checksum); miscompares++; end
    rst = 1'b0; tick(); rst = 1'b1;
    vectors++; if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || checksum !== 16'h0) begin $display("FAIL mid_reset got rdy=%b hold=%b sum=%h want 0/1/0000", in_ready, cpu_hold, checksum); miscompares++; end
    tick();
    vectors++; if (in_ready !== 1'b0 || done !== 1'b0) begin $display("FAIL mid_idle got rdy=%b done=%b want 0/0", in_ready, done); miscompares++; end
    do_start(20'h40, 21'd0);
    vectors++; if (done !== 1'b1 || checksum !== 16'h0 || cpu_hold !== 1'b0) begin $display("FAIL zero_count got done=%b sum=%h hold=%b want 1 0000 0", done, checksum, cpu_hold); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_backpressure();
    test_range_error();
    test_range_boundary();
    test_verify_mismatch();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
